// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Decode/issue stage. It classifies an ID packet, builds the immediate,
//   selects the ALU operands and the 4-bit ALU op, and holds the result in a
//   single-entry valid/ready register that feeds EX.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   id_valid_in/ready_out   ID handshake
//   id_instr_in             instruction word (ILEN)
//   id_pc_in                instruction PC (XLEN)
//   id_rs1/rs2_val_in       forwarded register values (XLEN)
//   flush_in                kill held entry and incoming packet
//   ex_valid_out/ready_in   EX handshake
//   ex_operand1/2_out       ALU operands (XLEN)
//   ex_alu_op_out           ALU op code
//   ex_rd_out               destination register (0 for stores/illegal)
//   ex_pc_out               PC of issued instruction
//   ex_illegal_out          instruction not handled by the ALU path
module alu_issue_stage #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid_in,
  output logic            id_ready_out,
  input  logic [ILEN-1:0] id_instr_in,
  input  logic [XLEN-1:0] id_pc_in,
  input  logic [XLEN-1:0] id_rs1_val_in,
  input  logic [XLEN-1:0] id_rs2_val_in,
  input  logic            flush_in,
  output logic            ex_valid_out,
  input  logic            ex_ready_in,
  output logic [XLEN-1:0] ex_operand1_out,
  output logic [XLEN-1:0] ex_operand2_out,
  output logic [3:0]      ex_alu_op_out,
  output logic [4:0]      ex_rd_out,
  output logic [XLEN-1:0] ex_pc_out,
  output logic            ex_illegal_out
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_MULH = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_REM  = 4'b1101;
  localparam logic [3:0] OP_ADDW = 4'b1110;
  localparam logic [3:0] OP_PASS = 4'b1111;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [3:0]      alu_op;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } ex_pkt_t;

  ex_pkt_t         pkt_d, pkt_q, dec;
  logic            valid_d, valid_q;
  logic            load;

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt;

  assign opc   = id_instr_in[6:0];
  assign f3    = id_instr_in[14:12];
  assign f7    = id_instr_in[31:25];
  assign imm_i = {{(XLEN-12){id_instr_in[31]}}, id_instr_in[31:20]};
  assign imm_s = {{(XLEN-12){id_instr_in[31]}}, id_instr_in[31:25], id_instr_in[11:7]};
  assign imm_u = {{(XLEN-32){id_instr_in[31]}}, id_instr_in[31:12], 12'b0};
  assign shamt = {{(XLEN-6){1'b0}}, id_instr_in[25:20]};

  // Decode. 'bad' collects every unsupported encoding; the illegal packet is
  // forced to a clean ADD 0,0 with rd=0 at the end so EX never sees junk.
  always_comb begin
    logic bad;
    bad         = 1'b0;
    dec         = '0;
    dec.op1     = id_rs1_val_in;
    dec.op2     = id_rs2_val_in;
    dec.alu_op  = OP_ADD;
    dec.rd      = id_instr_in[11:7];
    dec.pc      = id_pc_in;
    dec.illegal = 1'b0;
    case (opc)
      7'b0110011: begin
        case (f7)
          7'b0000000: case (f3)
            3'b000:  dec.alu_op = OP_ADD;
            3'b001:  dec.alu_op = OP_SLL;
            3'b100:  dec.alu_op = OP_XOR;
            3'b101:  dec.alu_op = OP_SRL;
            3'b110:  dec.alu_op = OP_OR;
            3'b111:  dec.alu_op = OP_AND;
            default: bad = 1'b1;
          endcase
          7'b0100000: case (f3)
            3'b000:  dec.alu_op = OP_SUB;
            3'b101:  dec.alu_op = OP_SRA;
            default: bad = 1'b1;
          endcase
          7'b0000001: case (f3)
            3'b000:  dec.alu_op = OP_MUL;
            3'b001:  dec.alu_op = OP_MULH;
            3'b100:  dec.alu_op = OP_DIV;
            3'b110:  dec.alu_op = OP_REM;
            default: bad = 1'b1;
          endcase
          default: bad = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec.op2 = imm_i;
        case (f3)
          3'b000: dec.alu_op = OP_ADD;
          3'b100: dec.alu_op = OP_XOR;
          3'b110: dec.alu_op = OP_OR;
          3'b111: dec.alu_op = OP_AND;
          3'b001: begin
            dec.op2    = shamt;
            dec.alu_op = OP_SLL;
            bad        = (id_instr_in[31:26] != 6'b000000);
          end
          3'b101: begin
            dec.op2 = shamt;
            if (id_instr_in[31:26] == 6'b000000)      dec.alu_op = OP_SRL;
            else if (id_instr_in[31:26] == 6'b010000) dec.alu_op = OP_SRA;
            else                                      bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      7'b0111011: begin
        dec.alu_op = OP_ADDW;
        bad        = (f7 != 7'b0000000) || (f3 != 3'b000);
      end
      7'b0011011: begin
        dec.alu_op = OP_ADDW;
        dec.op2    = imm_i;
        bad        = (f3 != 3'b000);
      end
      7'b0110111: begin
        dec.alu_op = OP_PASS;
        dec.op1    = '0;
        dec.op2    = imm_u;
      end
      7'b0010111: begin
        dec.op1 = id_pc_in;
        dec.op2 = imm_u;
      end
      7'b0000011: dec.op2 = imm_i;
      7'b0100011: begin
        dec.op2 = imm_s;
        dec.rd  = 5'd0;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec.op1     = '0;
      dec.op2     = '0;
      dec.alu_op  = OP_ADD;
      dec.rd      = 5'd0;
      dec.illegal = 1'b1;
    end
  end

  // Handshake. The entry can be replaced in the same cycle EX consumes it.
  assign id_ready_out = !valid_q || ex_ready_in;
  assign load         = id_valid_in && id_ready_out && !flush_in;

  always_comb begin
    pkt_d   = pkt_q;
    valid_d = valid_q;
    if (load)             pkt_d = dec;
    if (flush_in)         valid_d = 1'b0;
    else if (load)        valid_d = 1'b1;
    else if (ex_ready_in) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
    end
  end

  assign ex_valid_out    = valid_q;
  assign ex_operand1_out = pkt_q.op1;
  assign ex_operand2_out = pkt_q.op2;
  assign ex_alu_op_out   = pkt_q.alu_op;
  assign ex_rd_out       = pkt_q.rd;
  assign ex_pc_out       = pkt_q.pc;
  assign ex_illegal_out  = pkt_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, backpressure,
// replacement without bubble, flush and async reset.
module tb_alu_issue_stage;
  localparam int XLEN = 64;
  localparam int ILEN = 32;

  logic            clk, rst_n;
  logic            id_valid_in, id_ready_out;
  logic [ILEN-1:0] id_instr_in;
  logic [XLEN-1:0] id_pc_in, id_rs1_val_in, id_rs2_val_in;
  logic            flush_in, ex_valid_out, ex_ready_in;
  logic [XLEN-1:0] ex_operand1_out, ex_operand2_out, ex_pc_out;
  logic [3:0]      ex_alu_op_out;
  logic [4:0]      ex_rd_out;
  logic            ex_illegal_out;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_stage #(.XLEN(XLEN), .ILEN(ILEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_in(id_valid_in), .id_ready_out(id_ready_out),
    .id_instr_in(id_instr_in), .id_pc_in(id_pc_in),
    .id_rs1_val_in(id_rs1_val_in), .id_rs2_val_in(id_rs2_val_in),
    .flush_in(flush_in),
    .ex_valid_out(ex_valid_out), .ex_ready_in(ex_ready_in),
    .ex_operand1_out(ex_operand1_out), .ex_operand2_out(ex_operand2_out),
    .ex_alu_op_out(ex_alu_op_out), .ex_rd_out(ex_rd_out),
    .ex_pc_out(ex_pc_out), .ex_illegal_out(ex_illegal_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [63:0] pc,
                       input logic [63:0] r1, input logic [63:0] r2);
    @(negedge clk);
    id_valid_in   = 1'b1;
    id_instr_in   = ins;
    id_pc_in      = pc;
    id_rs1_val_in = r1;
    id_rs2_val_in = r2;
  endtask

  // Present a packet, let it be accepted, sample just after the edge.
  task automatic issue(input logic [31:0] ins, input logic [63:0] pc,
                       input logic [63:0] r1, input logic [63:0] r2);
    drive(ins, pc, r1, r2);
    @(posedge clk); #1;
    id_valid_in = 1'b0;
  endtask

  task automatic expect_pkt(input string tag, input logic [3:0] op, input logic [63:0] o1,
                            input logic [63:0] o2, input logic [4:0] rd, input logic ill);
    chk({tag, ".valid"}, {63'd0, ex_valid_out}, 64'd1);
    chk({tag, ".op"},    {60'd0, ex_alu_op_out}, {60'd0, op});
    chk({tag, ".op1"},   ex_operand1_out, o1);
    chk({tag, ".op2"},   ex_operand2_out, o2);
    chk({tag, ".rd"},    {59'd0, ex_rd_out}, {59'd0, rd});
    chk({tag, ".ill"},   {63'd0, ex_illegal_out}, {63'd0, ill});
  endtask

  initial begin
    rst_n = 1'b0; id_valid_in = 1'b0; id_instr_in = '0; id_pc_in = '0;
    id_rs1_val_in = '0; id_rs2_val_in = '0; flush_in = 1'b0; ex_ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", {63'd0, ex_valid_out}, 64'd0);
    chk("rst.op1",   ex_operand1_out, 64'd0);
    chk("rst.op",    {60'd0, ex_alu_op_out}, 64'd0);
    chk("rst.ready", {63'd0, id_ready_out}, 64'd1);
    @(negedge clk); rst_n = 1'b1;

    issue(32'h002081B3, 64'h100, 64'd5, 64'd7);
    expect_pkt("add", 4'b0000, 64'd5, 64'd7, 5'd3, 1'b0);
    chk("add.pc", ex_pc_out, 64'h100);

    issue(32'hFFF00093, 64'h104, 64'd10, 64'd99);
    expect_pkt("addi", 4'b0000, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 1'b0);

    issue(32'h43F0D093, 64'h108, 64'h1234, 64'd0);
    expect_pkt("srai", 4'b0111, 64'h1234, 64'd63, 5'd1, 1'b0);

    issue(32'h800000B7, 64'h10C, 64'h55, 64'h66);
    expect_pkt("lui", 4'b1111, 64'd0, 64'hFFFF_FFFF_8000_0000, 5'd1, 1'b0);

    issue(32'h0020A1B3, 64'h110, 64'd3, 64'd4);
    expect_pkt("slt", 4'b0000, 64'd0, 64'd0, 5'd0, 1'b1);

    issue(32'h00001097, 64'h1000, 64'd8, 64'd9);
    expect_pkt("auipc", 4'b0000, 64'h1000, 64'h1000, 5'd1, 1'b0);

    issue(32'h40208133, 64'h114, 64'd20, 64'd6);
    expect_pkt("sub", 4'b0001, 64'd20, 64'd6, 5'd2, 1'b0);

    issue(32'h0020B423, 64'h118, 64'h2000, 64'hAA);
    expect_pkt("sd", 4'b0000, 64'h2000, 64'd8, 5'd0, 1'b0);

    issue(32'h022081B3, 64'h11C, 64'd2, 64'd3);
    expect_pkt("mul", 4'b1010, 64'd2, 64'd3, 5'd3, 1'b0);

    issue(32'h002081BB, 64'h120, 64'd4, 64'd5);
    expect_pkt("addw", 4'b1110, 64'd4, 64'd5, 5'd3, 1'b0);

    // Backpressure: hold packet A while B waits.
    issue(32'h002081B3, 64'h200, 64'hA1, 64'hA2);
    drive(32'h002081B3, 64'h204, 64'hB1, 64'hB2);
    ex_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall.valid", {63'd0, ex_valid_out}, 64'd1);
      chk("stall.op1",   ex_operand1_out, 64'hA1);
      chk("stall.pc",    ex_pc_out, 64'h200);
      chk("stall.ready", {63'd0, id_ready_out}, 64'd0);
    end
    // Release with B pending: B replaces A on the next edge, no bubble.
    @(negedge clk); ex_ready_in = 1'b1; #1;
    chk("rel.ready", {63'd0, id_ready_out}, 64'd1);
    @(posedge clk); #1;
    id_valid_in = 1'b0;
    chk("repl.valid", {63'd0, ex_valid_out}, 64'd1);
    chk("repl.op1",   ex_operand1_out, 64'hB1);
    chk("repl.pc",    ex_pc_out, 64'h204);

    // No new packet and EX consumes: entry drains.
    @(posedge clk); #1;
    chk("drain.valid", {63'd0, ex_valid_out}, 64'd0);

    // Flush drops the incoming packet.
    issue(32'h002081B3, 64'h300, 64'd1, 64'd2);
    drive(32'h002081B3, 64'h304, 64'd3, 64'd4);
    flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0; id_valid_in = 1'b0;
    chk("flush.valid", {63'd0, ex_valid_out}, 64'd0);

    // Async reset mid-stall discards the held entry immediately.
    issue(32'h002081B3, 64'h400, 64'hC1, 64'hC2);
    ex_ready_in = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst.valid", {63'd0, ex_valid_out}, 64'd1);
    #2 rst_n = 1'b0; #1;
    chk("arst.valid", {63'd0, ex_valid_out}, 64'd0);
    chk("arst.op1",   ex_operand1_out, 64'd0);
    chk("arst.ready", {63'd0, id_ready_out}, 64'd1);
    @(negedge clk); rst_n = 1'b1; ex_ready_in = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage that drives the EX-stage ALU operand interface (ex_operand1, ex_operand2, ex_alu_op).
- Accepts a decoded-fetch packet from ID: instruction word, PC, rs1/rs2 register values.
- Classifies the instruction, builds the immediate, selects operands and produces the 4-bit ALU op code.
- Registers the result in a single-entry valid/ready pipeline register feeding EX; supports flush.

Parameters:
- XLEN, 64, datapath width of operands and PC.
- ILEN, 32, instruction word width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid_in  input  1  ID packet valid.
- id_ready_out  output  1  stage can accept the ID packet this cycle.
- id_instr_in  input  ILEN  instruction word.
- id_pc_in  input  XLEN  instruction PC.
- id_rs1_val_in  input  XLEN  rs1 value, already forwarded.
- id_rs2_val_in  input  XLEN  rs2 value, already forwarded.
- flush_in  input  1  kill the held entry and the incoming packet.
- ex_valid_out  output  1  EX packet valid.
- ex_ready_in  input  1  EX consumes the packet.
- ex_operand1_out  output  XLEN  ALU operand 1.
- ex_operand2_out  output  XLEN  ALU operand 2.
- ex_alu_op_out  output  4  ALU op code.
- ex_rd_out  output  5  destination register (instr[11:7]); 0 for stores.
- ex_pc_out  output  XLEN  PC of issued instruction.
- ex_illegal_out  output  1  instruction not supported by the ALU path.

Behaviour:
- ALU op encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA.
  - 1010 MUL, 1011 MULH, 1100 DIV, 1101 REM.
  - 1110 ADDW (sign-extended low 32 bits), 1111 PASS operand2.
  - 1000/1001 are never generated.
- Decode by opcode instr[6:0]; f3 = instr[14:12], f7 = instr[31:25]:
  - 0110011 OP: f7=0000000 gives f3 000 ADD, 001 SLL, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - 0110011 OP: f7=0100000 gives 000 SUB, 101 SRA.
  - 0110011 OP: f7=0000001 gives 000 MUL, 001 MULH, 100 DIV, 110 REM.
  - For OP, operand1=rs1, operand2=rs2.
  - 0010011 OP-IMM: 000 ADD, 100 XOR, 110 OR, 111 AND. operand1=rs1, operand2=sext(I-imm).
  - 0010011 OP-IMM shifts: 001 SLL requires instr[31:26]=000000. 101 gives SRL if instr[31:26]=000000, SRA if 010000. operand2={58'b0, instr[25:20]}.
  - 0111011 OP-32: f7=0, f3=000 gives ADDW (rs1, rs2).
  - 0011011 OP-IMM-32: f3=000 gives ADDW (rs1, sext(I-imm)).
  - 0110111 LUI: PASS, operand1=0, operand2=sext({instr[31:12],12'b0}).
  - 0010111 AUIPC: ADD, operand1=pc, operand2=sext({instr[31:12],12'b0}).
  - 0000011 LOAD: ADD, rs1 + sext(I-imm).
  - 0100011 STORE: ADD, rs1 + sext(S-imm {instr[31:25],instr[11:7]}); rd forced 0.
  - Any other encoding (incl. SLT/SLTU, unlisted f3/f7): illegal=1, op=ADD, operand1=operand2=0, rd=0.
- Handshake:
  - Single entry: id_ready_out = !ex_valid_out || ex_ready_in (combinational, no flush term).
  - Load on id_valid_in && id_ready_out && !flush_in.
  - ex_valid_out clears when ex_ready_in with no load.
  - Outputs stable while ex_valid_out && !ex_ready_in.
- Latency: an accepted packet is visible on ex_* one cycle after acceptance. Back-to-back throughput is 1/cycle when ex_ready_in stays high.
- Flush: flush_in has priority. Next cycle ex_valid_out=0 and the incoming packet is dropped even if id_valid_in=1. Data registers may hold stale values.
- Reset (async, rst_n=0):
  - ex_valid_out=0.
  - All ex_* data outputs=0, ex_illegal_out=0, ex_alu_op_out=0000.
  - id_ready_out=1 after reset.
  - Reset mid-transfer discards the held entry.
- Simultaneous EX consume and ID accept in the same cycle: the new packet replaces the old one, ex_valid_out stays 1.

Test Plan:
- ADD reset check: reset, then issue ADD x3,x1,x2 (0x002081B3) with rs1=5, rs2=7 -> next cycle valid=1, op=0000, op1=5, op2=7, rd=3.
- ADDI sign extension: ADDI imm=-1 (0xFFF00093), rs1=10 -> op=0000, op2=0xFFFF_FFFF_FFFF_FFFF.
- SRAI shift amount: SRAI shamt 63 (0x43F0D093) -> op=0111, op2=63.
- LUI immediate: LUI 0x80000 -> op=1111, op2=0xFFFF_FFFF_8000_0000.
- Illegal and PC path: SLT (0x0020A1B3) -> illegal=1, op=0000, op1=op2=0. AUIPC with pc=0x1000, imm=1 -> op1=0x1000, op2=0x1000.
- Backpressure and flush:
  - Hold ex_ready_in=0 for 3 cycles -> outputs stable, id_ready_out=0.
  - Release with a new packet pending -> replacement without a bubble.
  - Assert flush_in with id_valid_in=1 -> ex_valid_out=0 next cycle.
  - Assert rst_n low mid-stall -> valid drops immediately.
